// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control unit: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer driving PC, IR and datapath strobes.
// Optional feature: define MULTICYCLE_CTRL_TRAP_EN to trap unsupported instructions into HALT with illegal=1.
module multicycle_ctrl #(
    parameter int          ADDR_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ready,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ready,
    input  logic              alu_zero,
    input  logic [31:0]       rs_data,
    output logic [31:0]       instr_q,
    output logic [ADDR_W-1:0] pc,
    output logic              reg_write,
    output logic              reg_dst,
    output logic              alu_src,
    output logic              mem_to_reg,
    output logic              link,
    output logic [3:0]        alu_ctrl,
    output logic              halted,
    output logic              illegal
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_d;
    logic              illegal_q, illegal_d;

    logic [5:0]        opcode, funct;
    logic              is_r, is_r_alu, is_jr, is_j, is_jal, is_beq;
    logic              is_addi, is_lw, is_sw, is_halt, supported;
    logic [31:0]       jump_full, branch_off;
    logic [ADDR_W-1:0] jump_tgt, branch_tgt;

    // Instruction-field decode is purely a function of the instruction register.
    always_comb begin
        opcode   = instr_q[31:26];
        funct    = instr_q[5:0];
        is_r     = (opcode == OP_RTYPE);
        is_r_alu = is_r && (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                            funct == FN_OR  || funct == FN_SLT);
        is_jr    = is_r && (funct == FN_JR);
        is_j     = (opcode == OP_J);
        is_jal   = (opcode == OP_JAL);
        is_beq   = (opcode == OP_BEQ);
        is_addi  = (opcode == OP_ADDI);
        is_lw    = (opcode == OP_LW);
        is_sw    = (opcode == OP_SW);
        is_halt  = (opcode == OP_HALT);
        supported = is_r_alu || is_jr || is_j || is_jal || is_beq ||
                    is_addi || is_lw || is_sw || is_halt;

        // Jump keeps the top PC nibble; narrower PCs simply drop the bits above ADDR_W.
        jump_full       = 32'(pc_q);
        jump_full[27:0] = {instr_q[25:0], 2'b00};
        jump_tgt        = jump_full[ADDR_W-1:0];

        branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        branch_tgt = pc_q + branch_off[ADDR_W-1:0];
    end

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        illegal_d = illegal_q;

        unique case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    pc_d    = pc_q + ADDR_W'(4);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_j || is_jal) begin
                    pc_d    = jump_tgt;
                    state_d = is_jal ? S_WB : S_FETCH;
                end else if (is_jr) begin
                    pc_d    = rs_data[ADDR_W-1:0];
                    state_d = S_FETCH;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else if (!supported) begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
`else
                    state_d   = S_FETCH;
`endif
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else if (is_beq) begin
                    if (alu_zero) pc_d = branch_tgt;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ready) state_d = is_lw ? S_WB : S_FETCH;
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC[ADDR_W-1:0];
            instr_q   <= 32'h0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            illegal_q <= illegal_d;
        end
    end

    // Strobes are masked while reset is held so no handshake starts until release.
    always_comb begin
        imem_req   = rst && (state_q == S_FETCH);
        dmem_req   = rst && (state_q == S_MEM);
        dmem_we    = dmem_req && is_sw;
        reg_write  = rst && (state_q == S_WB);
        reg_dst    = reg_write && is_r;
        mem_to_reg = reg_write && is_lw;
        link       = reg_write && is_jal;
        halted     = rst && (state_q == S_HALT);
        illegal    = rst && illegal_q;
        imem_addr  = pc_q;
        pc         = pc_q;

        alu_src  = is_addi || is_lw || is_sw;
        alu_ctrl = 4'b0010;
        if (is_beq) begin
            alu_ctrl = 4'b0110;
        end else if (is_r) begin
            case (funct)
                FN_SUB:  alu_ctrl = 4'b0110;
                FN_AND:  alu_ctrl = 4'b0000;
                FN_OR:   alu_ctrl = 4'b0001;
                FN_SLT:  alu_ctrl = 4'b0111;
                default: alu_ctrl = 4'b0010;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: an instruction-level model expands each directed instruction
// into its expected per-cycle output trace, and one negedge process compares the DUT against that trace.
module tb_multicycle_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0;

    localparam logic [31:0] I_ADD  = 32'h0022_1820; // add  $3,$1,$2
    localparam logic [31:0] I_SUB  = 32'h0022_2022; // sub  $4,$1,$2
    localparam logic [31:0] I_AND  = 32'h0022_2824; // and  $5,$1,$2
    localparam logic [31:0] I_OR   = 32'h0022_3025; // or   $6,$1,$2
    localparam logic [31:0] I_SLT  = 32'h0022_382A; // slt  $7,$1,$2
    localparam logic [31:0] I_ADDI = 32'h2022_0005; // addi $2,$1,5
    localparam logic [31:0] I_LW   = 32'h8C22_0008; // lw   $2,8($1)
    localparam logic [31:0] I_SW   = 32'hAC22_0008; // sw   $2,8($1)
    localparam logic [31:0] I_BEQ  = 32'h1022_FFFF; // beq  $1,$2,-1
    localparam logic [31:0] I_JAL  = 32'h0C00_0040; // jal  0x100
    localparam logic [31:0] I_J    = 32'h0800_0080; // j    0x200
    localparam logic [31:0] I_JR   = 32'h0020_0008; // jr   $1
    localparam logic [31:0] I_HALT = 32'hFC00_0000;
    localparam logic [31:0] I_BAD  = 32'hF800_0000; // opcode 0x3E

    typedef enum {C_R, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR, C_HALT, C_BAD} cls_t;

    typedef struct {
        logic        imem_req;
        logic [31:0] imem_addr;
        logic        dmem_req;
        logic        dmem_we;
        logic        reg_write;
        logic        link;
        logic        halted;
        logic        illegal;
        logic        chk_pc;
        logic [31:0] pc;
        logic        chk_wb;
        logic        reg_dst;
        logic        mem_to_reg;
        logic        chk_alu;
        logic [3:0]  alu_ctrl;
        logic        alu_src;
        logic        chk_instr;
        logic [31:0] instr;
    } exp_t;

    logic        clk, rst;
    logic        imem_req, dmem_req, dmem_we, imem_ready, dmem_ready, alu_zero;
    logic [31:0] imem_addr, imem_rdata, rs_data, instr_q, pc;
    logic        reg_write, reg_dst, alu_src, mem_to_reg, link, halted, illegal;
    logic [3:0]  alu_ctrl;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    exp_t cur;
    logic [31:0] m_pc;
    bit   trap_en;

    multicycle_ctrl #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .alu_zero(alu_zero), .rs_data(rs_data), .instr_q(instr_q), .pc(pc),
        .reg_write(reg_write), .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
        .link(link), .alu_ctrl(alu_ctrl), .halted(halted), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic cls_t classify(input logic [31:0] ins);
        logic [5:0] op, fn;
        op = ins[31:26];
        fn = ins[5:0];
        case (op)
            6'h00: begin
                if (fn == 6'h08) return C_JR;
                if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A) return C_R;
                return C_BAD;
            end
            6'h08:   return C_ADDI;
            6'h23:   return C_LW;
            6'h2B:   return C_SW;
            6'h04:   return C_BEQ;
            6'h02:   return C_J;
            6'h03:   return C_JAL;
            6'h3F:   return C_HALT;
            default: return C_BAD;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [31:0] ins);
        case (classify(ins))
            C_BEQ: return 4'b0110;
            C_R: begin
                case (ins[5:0])
                    6'h22:   return 4'b0110;
                    6'h24:   return 4'b0000;
                    6'h25:   return 4'b0001;
                    6'h2A:   return 4'b0111;
                    default: return 4'b0010;
                endcase
            end
            default: return 4'b0010;
        endcase
    endfunction

    function automatic exp_t idle(input logic [31:0] p);
        exp_t e;
        e = '{default: '0};
        e.chk_pc = 1'b1;
        e.pc     = p;
        return e;
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check("imem_req", imem_req, cur.imem_req);
            if (cur.imem_req) check("imem_addr", imem_addr, cur.imem_addr);
            check("dmem_req", dmem_req, cur.dmem_req);
            check("dmem_we", dmem_we, cur.dmem_we);
            check("reg_write", reg_write, cur.reg_write);
            check("link", link, cur.link);
            check("halted", halted, cur.halted);
            check("illegal", illegal, cur.illegal);
            if (cur.chk_pc) check("pc", pc, cur.pc);
            if (cur.chk_wb) begin
                check("reg_dst", reg_dst, cur.reg_dst);
                check("mem_to_reg", mem_to_reg, cur.mem_to_reg);
            end
            if (cur.chk_alu) begin
                check("alu_ctrl", alu_ctrl, cur.alu_ctrl);
                check("alu_src", alu_src, cur.alu_src);
            end
            if (cur.chk_instr) check("instr_q", instr_q, cur.instr);
        end
    end

    task automatic cycle(input exp_t e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        alu_zero   = 1'b0;
        imem_rdata = I_HALT;
    endtask

    task automatic reset_seq(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            rst        = 1'b0;
            imem_ready = 1'b1;
            dmem_ready = 1'b1;
            imem_rdata = I_ADD;
            e = idle(32'h0);
            e.chk_pc = 1'b0;
            cycle(e);
        end
        m_pc = RESET_PC;
    endtask

    task automatic halt_cycles(input logic [31:0] p, input logic ill);
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            imem_ready = 1'b1;
            dmem_ready = 1'b1;
            e = idle(p);
            e.halted  = 1'b1;
            e.illegal = ill;
            cycle(e);
        end
    endtask

    // Expands one instruction into its cycle-by-cycle expected outputs and advances the model PC.
    task automatic run_instr(input logic [31:0] ins, input int wi, input int wd, input logic z,
                             input logic [31:0] rsv, input bit abort_mem, output int ncyc);
        exp_t        e;
        cls_t        c;
        logic [31:0] pc0, pc1, tgt;
        c   = classify(ins);
        pc0 = m_pc;
        pc1 = pc0 + 32'd4;
        tgt = {pc1[31:28], ins[25:0], 2'b00};
        ncyc = 0;
        rs_data = rsv;
        for (int k = 0; k <= wi; k++) begin
            imem_ready = (k == wi);
            imem_rdata = (k == wi) ? ins : I_HALT;
            e = idle(pc0);
            e.imem_req  = 1'b1;
            e.imem_addr = pc0;
            cycle(e);
            ncyc++;
        end
        e = idle(pc1);
        e.chk_instr = 1'b1;
        e.instr     = ins;
        cycle(e);
        ncyc++;
        m_pc = pc1;
        case (c)
            C_J:  m_pc = tgt;
            C_JR: m_pc = rsv;
            C_JAL: begin
                e = idle(tgt);
                e.reg_write = 1'b1;
                e.link      = 1'b1;
                e.chk_wb    = 1'b1;
                cycle(e);
                ncyc++;
                m_pc = tgt;
            end
            C_HALT: halt_cycles(pc1, 1'b0);
            C_BAD:  if (trap_en) halt_cycles(pc1, 1'b1);
            default: begin
                e = idle(pc1);
                e.chk_alu  = 1'b1;
                e.alu_ctrl = alu_of(ins);
                e.alu_src  = (c == C_ADDI || c == C_LW || c == C_SW);
                if (c == C_BEQ) alu_zero = z;
                cycle(e);
                ncyc++;
                if (c == C_BEQ && z) m_pc = pc1 + 32'(int'($signed(ins[15:0])) * 4);
                if (c == C_LW || c == C_SW) begin
                    for (int k = 0; k <= wd; k++) begin
                        dmem_ready = (k == wd);
                        e.dmem_req = 1'b1;
                        e.dmem_we  = (c == C_SW);
                        if (abort_mem && k == 1) return;
                        cycle(e);
                        ncyc++;
                    end
                end
                if (c == C_R || c == C_ADDI || c == C_LW) begin
                    e = idle(pc1);
                    e.reg_write  = 1'b1;
                    e.chk_wb     = 1'b1;
                    e.reg_dst    = (c == C_R);
                    e.mem_to_reg = (c == C_LW);
                    cycle(e);
                    ncyc++;
                end
            end
        endcase
    endtask

    initial begin
        int n;
`ifdef MULTICYCLE_CTRL_TRAP_EN
        trap_en = 1'b1;
`else
        trap_en = 1'b0;
`endif
        rst = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; alu_zero = 1'b0;
        imem_rdata = I_HALT; rs_data = 32'h0; m_pc = RESET_PC;
        @(posedge clk);
        #1;
        reset_seq(2);
        rst = 1'b1;
        #1;
        check("rst_imem_req", imem_req, 1'b1);
        check("rst_pc", pc, 32'h0);
        check("rst_strobes", {dmem_req, dmem_we, reg_write, link, halted, illegal}, 6'b0);

        run_instr(I_ADD, 3, 0, 1'b0, 32'h0, 0, n);  check("add_cycles", n, 7);
        run_instr(I_SUB, 0, 0, 1'b0, 32'h0, 0, n);  check("sub_cycles", n, 4);
        run_instr(I_LW, 0, 2, 1'b0, 32'h0, 0, n);   check("lw_cycles", n, 7);
        run_instr(I_SW, 0, 0, 1'b0, 32'h0, 0, n);   check("sw_cycles", n, 4);
        check("pc_before_beq", pc, 32'h10);
        run_instr(I_BEQ, 0, 0, 1'b1, 32'h0, 0, n);  check("beq_taken_pc", pc, 32'h10);
        check("beq_cycles", n, 3);
        run_instr(I_BEQ, 0, 0, 1'b0, 32'h0, 0, n);  check("beq_not_taken_pc", pc, 32'h14);
        run_instr(I_AND, 1, 0, 1'b0, 32'h0, 0, n);
        run_instr(I_OR, 0, 0, 1'b0, 32'h0, 0, n);
        run_instr(I_SLT, 0, 0, 1'b0, 32'h0, 0, n);
        check("pc_before_jal", pc, 32'h20);
        run_instr(I_JAL, 0, 0, 1'b0, 32'h0, 0, n);  check("jal_pc", pc, 32'h100);
        check("jal_cycles", n, 3);
        run_instr(I_ADDI, 0, 0, 1'b0, 32'h0, 0, n); check("addi_cycles", n, 4);
        run_instr(I_JR, 0, 0, 1'b0, 32'h44, 0, n);  check("jr_pc", pc, 32'h44);
        check("jr_cycles", n, 2);
        run_instr(I_J, 0, 0, 1'b0, 32'h0, 0, n);    check("j_pc", pc, 32'h200);

        run_instr(I_LW, 0, 5, 1'b0, 32'h0, 1, n);
        reset_seq(1);
        rst = 1'b1;
        #1;
        check("mem_rst_imem_req", imem_req, 1'b1);
        check("mem_rst_pc", pc, 32'h0);

        run_instr(I_BAD, 0, 0, 1'b0, 32'h0, 0, n);
        if (trap_en) begin
            check("trap_halted", halted, 1'b1);
            check("trap_illegal", illegal, 1'b1);
            reset_seq(2);
            rst = 1'b1;
            #1;
            check("trap_rst_illegal", illegal, 1'b0);
        end else begin
            check("nop_pc", pc, 32'h4);
            check("nop_illegal", illegal, 1'b0);
            run_instr(I_HALT, 0, 0, 1'b0, 32'h0, 0, n);
            check("halt_halted", halted, 1'b1);
            reset_seq(1);
            rst = 1'b1;
            #1;
        end
        check("final_halted", halted, 1'b0);
        check("final_pc", pc, 32'h0);

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
